// File: rtl/bank_response_latency_statistics_if.sv
// Request/response handshake seen by one bank's latency monitor.
interface bank_response_latency_statistics_if #(
    parameter int unsigned ID_WIDTH = 32
);
    logic                req_fire;
    logic [ID_WIDTH-1:0] req_id;
    logic                resp_fire;
    logic [ID_WIDTH-1:0] resp_id;

    modport master (output req_fire, req_id, resp_fire, resp_id);
    modport slave  (input  req_fire, req_id, resp_fire, resp_id);
endinterface

// File: rtl/bank_response_latency_statistics.sv
// Per-bank request->response latency monitor: tracks in-flight IDs, accumulates
// count/sum/min/max plus a latency histogram, read back through a registered select port.
module bank_response_latency_statistics #(
    parameter int unsigned RANK            = 0,
    parameter int unsigned BANK            = 0,
    parameter int unsigned ID_WIDTH        = 32,
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter int unsigned HIST_BINS       = 16,
    parameter int unsigned BIN_SHIFT       = 2,
    localparam int unsigned OCW            = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    bank_response_latency_statistics_if.slave   bus,
    input  logic [63:0]                         globalCycle,
    input  logic                                clear,
    input  logic [7:0]                          stat_sel,
    output logic [63:0]                         stat_data,
    output logic [OCW-1:0]                      outstanding,
    output logic                                overflow,
    output logic                                orphan
);
    localparam int unsigned IDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned BW    = $clog2(HIST_BINS);
    localparam int unsigned HLIM  = 8 + HIST_BINS;

    logic [MAX_OUTSTANDING-1:0] valid;
    logic [ID_WIDTH-1:0]        ids [MAX_OUTSTANDING];
    logic [63:0]                ts  [MAX_OUTSTANDING];

    logic [31:0] count, min_lat, max_lat, dropped, orphans;
    logic [63:0] sum;
    logic [31:0] hist [HIST_BINS];

    logic             free_found, match_found;
    logic [IDX_W-1:0] free_idx, match_idx;
    logic             alloc, drop, hit, miss;
    logic [63:0]      lat64;
    logic [31:0]      lat, shifted;
    logic [BW-1:0]    bin_idx;
    logic [64:0]      sum_ext;
    logic [63:0]      rd;

    // Both searches use the pre-edge valid vector, so a same-cycle response can
    // neither free room for nor match the same-cycle request.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        match_found = 1'b0;
        match_idx   = '0;
        for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            if (!valid[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (valid[i] && ids[i] == bus.resp_id && !match_found) begin
                match_found = 1'b1;
                match_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        alloc   = bus.req_fire && free_found;
        drop    = bus.req_fire && !free_found;
        hit     = bus.resp_fire && match_found;
        miss    = bus.resp_fire && !match_found;
        lat64   = globalCycle - ts[match_idx];
        lat     = (|lat64[63:32]) ? '1 : lat64[31:0];
        shifted = lat >> BIN_SHIFT;
        bin_idx = (shifted >= HIST_BINS) ? BW'(HIST_BINS - 1) : BW'(shifted);
        sum_ext = {1'b0, sum} + {33'b0, lat};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid       <= '0;
            outstanding <= '0;
        end else begin
            if (alloc) valid[free_idx] <= 1'b1;
            if (hit)   valid[match_idx] <= 1'b0;
            outstanding <= outstanding + OCW'(alloc) - OCW'(hit);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            ids[free_idx] <= bus.req_id;
            ts[free_idx]  <= globalCycle;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            sum      <= '0;
            min_lat  <= '1;
            max_lat  <= '0;
            dropped  <= '0;
            orphans  <= '0;
            overflow <= 1'b0;
            orphan   <= 1'b0;
            for (int unsigned i = 0; i < HIST_BINS; i++) hist[i] <= '0;
        end else if (clear) begin
            count    <= '0;
            sum      <= '0;
            min_lat  <= '1;
            max_lat  <= '0;
            dropped  <= '0;
            orphans  <= '0;
            overflow <= 1'b0;
            orphan   <= 1'b0;
            for (int unsigned i = 0; i < HIST_BINS; i++) hist[i] <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
                if (dropped != '1) dropped <= dropped + 32'd1;
            end
            if (miss) begin
                orphan <= 1'b1;
                if (orphans != '1) orphans <= orphans + 32'd1;
            end
            if (hit) begin
                if (count != '1) count <= count + 32'd1;
                sum <= sum_ext[64] ? '1 : sum_ext[63:0];
                if (lat < min_lat) min_lat <= lat;
                if (lat > max_lat) max_lat <= lat;
                if (hist[bin_idx] != '1) hist[bin_idx] <= hist[bin_idx] + 32'd1;
            end
        end
    end

    always_comb begin
        rd = '0;
        case (stat_sel)
            8'h00: rd = {32'b0, count};
            8'h01: rd = sum;
            8'h02: rd = {32'b0, min_lat};
            8'h03: rd = {32'b0, max_lat};
            8'h04: rd = {32'b0, dropped};
            8'h05: rd = {32'b0, orphans};
            8'h06: rd = 64'(outstanding);
            8'hFE: rd = 64'(RANK);
            8'hFF: rd = 64'(BANK);
            default: begin
                if (32'(stat_sel) >= 32'd8 && 32'(stat_sel) < HLIM)
                    rd = {32'b0, hist[BW'(stat_sel - 8'd8)]};
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stat_data <= '0;
        else        stat_data <= rd;
    end
endmodule

// File: tb/tb_bank_response_latency_statistics.sv
// Directed self-checking bench for bank_response_latency_statistics.
module tb_bank_response_latency_statistics;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] globalCycle = '0;
    logic        clear = 1'b0;
    logic [7:0]  stat_sel = '0;
    logic [63:0] stat_data;
    logic [4:0]  outstanding;
    logic        overflow, orphan;

    int unsigned checks = 0;
    int unsigned errors = 0;

    bank_response_latency_statistics_if #(.ID_WIDTH(32)) bus ();

    bank_response_latency_statistics #(
        .RANK(3),
        .BANK(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave),
        .globalCycle(globalCycle),
        .clear(clear),
        .stat_sel(stat_sel),
        .stat_data(stat_data),
        .outstanding(outstanding),
        .overflow(overflow),
        .orphan(orphan)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] rid;
        logic        resp;
        logic [31:0] sid;
        logic [63:0] gc;
        logic [4:0]  exp_out;
        logic        exp_ovf;
        logic        exp_orph;
    } vec_t;

    typedef struct {
        logic [7:0]  sel;
        logic [63:0] exp;
    } rd_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic req, input logic [31:0] rid, input logic resp,
                       input logic [31:0] sid, input logic [63:0] gc, input logic clr);
        @(negedge clk);
        bus.req_fire  = req;
        bus.req_id    = rid;
        bus.resp_fire = resp;
        bus.resp_id   = sid;
        globalCycle   = gc;
        clear         = clr;
        @(posedge clk);
        #1;
        bus.req_fire  = 1'b0;
        bus.resp_fire = 1'b0;
        clear         = 1'b0;
    endtask

    task automatic rd(input string name, input logic [7:0] sel, input logic [63:0] exp);
        @(negedge clk);
        stat_sel = sel;
        @(posedge clk);
        #1;
        chk(name, stat_data, exp);
    endtask

    task automatic flags(input string name, input logic [4:0] o, input logic ov, input logic orp);
        chk({name, ".outstanding"}, 64'(outstanding), 64'(o));
        chk({name, ".overflow"}, 64'(overflow), 64'(ov));
        chk({name, ".orphan"}, 64'(orphan), 64'(orp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t va[5];
        rd_t  ra[13];
        rd_t  r0[7];

        bus.req_fire  = 1'b0;
        bus.req_id    = '0;
        bus.resp_fire = 1'b0;
        bus.resp_id   = '0;

        r0[0] = '{8'h00, 64'd0};
        r0[1] = '{8'h01, 64'd0};
        r0[2] = '{8'h02, 64'hFFFF_FFFF};
        r0[3] = '{8'h03, 64'd0};
        r0[4] = '{8'h04, 64'd0};
        r0[5] = '{8'h05, 64'd0};
        r0[6] = '{8'h06, 64'd0};

        // round trip, orphan on empty table, same-id same-cycle req/resp, later match
        va[0] = '{1'b1, 32'd5, 1'b0, 32'd0, 64'd100, 5'd1, 1'b0, 1'b0};
        va[1] = '{1'b0, 32'd0, 1'b1, 32'd5, 64'd112, 5'd0, 1'b0, 1'b0};
        va[2] = '{1'b0, 32'd0, 1'b1, 32'd9, 64'd120, 5'd0, 1'b0, 1'b1};
        va[3] = '{1'b1, 32'd7, 1'b1, 32'd7, 64'd130, 5'd1, 1'b0, 1'b1};
        va[4] = '{1'b0, 32'd0, 1'b1, 32'd7, 64'd140, 5'd0, 1'b0, 1'b1};

        ra[0]  = '{8'h00, 64'd2};
        ra[1]  = '{8'h01, 64'd22};
        ra[2]  = '{8'h02, 64'd10};
        ra[3]  = '{8'h03, 64'd12};
        ra[4]  = '{8'h04, 64'd0};
        ra[5]  = '{8'h05, 64'd2};
        ra[6]  = '{8'h06, 64'd0};
        ra[7]  = '{8'h08, 64'd0};
        ra[8]  = '{8'h0A, 64'd1};
        ra[9]  = '{8'h0B, 64'd1};
        ra[10] = '{8'h07, 64'd0};
        ra[11] = '{8'hFE, 64'd3};
        ra[12] = '{8'hFF, 64'd5};

        // Reset state
        repeat (3) @(negedge clk);
        chk("in_reset.stat_data", stat_data, 64'd0);
        reset = 1'b1;
        flags("reset", 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) rd($sformatf("reset.sel%0d", r0[i].sel), r0[i].sel, r0[i].exp);

        // Table-driven traffic
        for (int i = 0; i < 5; i++) begin
            cyc(va[i].req, va[i].rid, va[i].resp, va[i].sid, va[i].gc, 1'b0);
            flags($sformatf("vec%0d", i), va[i].exp_out, va[i].exp_ovf, va[i].exp_orph);
        end
        for (int i = 0; i < 13; i++) rd($sformatf("vec.sel%0h", ra[i].sel), ra[i].sel, ra[i].exp);

        // Fill the table, overflow, then same-cycle resp+req while full
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1'b1, 32'(100 + i), 1'b0, 32'd0, 64'(200 + i), 1'b0);
        flags("fill16", 5'd16, 1'b0, 1'b0);
        cyc(1'b1, 32'd200, 1'b0, 32'd0, 64'd240, 1'b0);
        flags("fill17", 5'd16, 1'b1, 1'b0);
        rd("fill17.dropped", 8'h04, 64'd1);
        cyc(1'b1, 32'd300, 1'b1, 32'd100, 64'd250, 1'b0);
        flags("full_rr", 5'd15, 1'b1, 1'b0);
        rd("full_rr.dropped", 8'h04, 64'd2);
        rd("full_rr.count", 8'h00, 64'd1);
        rd("full_rr.max", 8'h03, 64'd50);
        rd("full_rr.hist12", 8'h14, 64'd1);
        cyc(1'b0, 32'd0, 1'b1, 32'd300, 64'd260, 1'b0);
        flags("dropped_id", 5'd15, 1'b1, 1'b1);

        // Wrap-safe latency and 32-bit clamp into the last bin
        do_reset();
        cyc(1'b1, 32'd1, 1'b0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 32'd1, 64'd4, 1'b0);
        rd("wrap.sum", 8'h01, 64'd7);
        rd("wrap.hist1", 8'h09, 64'd1);
        cyc(1'b1, 32'd2, 1'b0, 32'd0, 64'd0, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 32'd2, 64'h2_0000_0000, 1'b0);
        rd("clamp.max", 8'h03, 64'hFFFF_FFFF);
        rd("clamp.min", 8'h02, 64'd7);
        rd("clamp.sum", 8'h01, 64'h1_0000_0006);
        rd("clamp.hist15", 8'h17, 64'd1);
        rd("clamp.count", 8'h00, 64'd2);

        // Clear coincident with a matching response
        cyc(1'b1, 32'd10, 1'b0, 32'd0, 64'd1000, 1'b0);
        cyc(1'b1, 32'd11, 1'b0, 32'd0, 64'd1001, 1'b0);
        cyc(1'b1, 32'd12, 1'b0, 32'd0, 64'd1002, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 32'd99, 64'd1003, 1'b0);
        flags("pre_clear", 5'd3, 1'b0, 1'b1);
        cyc(1'b0, 32'd0, 1'b1, 32'd11, 64'd1010, 1'b1);
        flags("clear", 5'd2, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) rd($sformatf("clear.sel%0d", r0[i].sel), r0[i].sel, r0[i].exp);
        rd("clear.hist15", 8'h17, 64'd0);
        cyc(1'b0, 32'd0, 1'b1, 32'd10, 64'd1020, 1'b0);
        flags("post_clear", 5'd1, 1'b0, 1'b0);
        rd("post_clear.sum", 8'h01, 64'd20);

        // Async reset in the middle of a cycle with traffic pending
        @(negedge clk);
        stat_sel     = 8'h01;
        bus.req_fire = 1'b1;
        bus.req_id   = 32'd50;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        flags("async", 5'd0, 1'b0, 1'b0);
        chk("async.stat_data", stat_data, 64'd0);
        bus.req_fire = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        rd("async.count", 8'h00, 64'd0);
        cyc(1'b0, 32'd0, 1'b1, 32'd12, 64'd1100, 1'b0);
        flags("async.table", 5'd0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
